far_path_pipe: RTL

- Pipelined, handshaked successor to the combinational far-path adder used in the FPU add datapath.
- Accepts unswapped operands and does swap, exponent difference, effective-op detection, sticky alignment, add/sub and 1-bit normalisation over 2 register stages.
- Flags operand pairs that belong to the near path.
- Sits between the FPU unpack stage and the rounding stage.

---
 rtl/far_path_pipe_pkg.sv | 18 +
 rtl/far_path_pipe_norm.sv | 53 +++++
 rtl/far_path_pipe.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/far_path_pipe_pkg.sv
// Shared FPU add-path definitions: normalisation case encoding and adder sizing.
package far_path_pipe_pkg;

    typedef enum logic [1:0] {
        NORM_CANCEL   = 2'b00,
        NORM_KEEP     = 2'b01,
        NORM_CARRY    = 2'b10,
        NORM_CARRY_HI = 2'b11
    } norm_case_e;

    // One carry bit above, three guard/sticky positions below the significand.
    localparam int ADD_GUARD = 4;

    function automatic int add_width(input int precision);
        return precision + ADD_GUARD;
    endfunction

endpackage

// File: rtl/far_path_pipe_norm.sv
// Stage-2 one-bit normalisation select on the far-path sum.
module far_path_pipe_norm
    import far_path_pipe_pkg::*;
#(
    parameter int EXPWIDTH  = 8,
    parameter int PRECISION = 48,
    parameter int OUTPC     = 24
) (
    input  logic [PRECISION+3:0] sum,
    input  logic                 small_add,
    input  logic [EXPWIDTH-1:0]  l_exp,
    output logic [OUTPC+2:0]     sig,
    output logic [EXPWIDTH-1:0]  res_exp,
    output logic                 exp_ovf
);
    localparam int P = PRECISION;
    localparam logic [EXPWIDTH-1:0] EXP_MAX_M1 = {{(EXPWIDTH-1){1'b1}}, 1'b0};

    norm_case_e         ncase;
    logic [OUTPC+2:0]   carry_sig;
    logic [OUTPC+2:0]   keep_sig;
    logic [OUTPC+2:0]   cancel_sig;

    assign ncase      = norm_case_e'(sum[P+3:P+2]);
    assign carry_sig  = {sum[P+3:P-OUTPC+2], |sum[P-OUTPC+1:0]};
    assign keep_sig   = {sum[P+2:P-OUTPC+1], |sum[P-OUTPC:0]};
    assign cancel_sig = {sum[P+1:P-OUTPC], |sum[P-OUTPC-1:0]};

    always_comb begin
        sig     = keep_sig;
        res_exp = l_exp;
        exp_ovf = 1'b0;
        unique case (ncase)
            NORM_CARRY, NORM_CARRY_HI: begin
                sig     = carry_sig;
                res_exp = l_exp + 1'b1;
                exp_ovf = (l_exp == EXP_MAX_M1);
            end
            NORM_KEEP: begin
                sig     = keep_sig;
                res_exp = l_exp;
            end
            NORM_CANCEL: begin
                // Subnormal pairs never renormalise left.
                if (!small_add) begin
                    sig     = cancel_sig;
                    res_exp = l_exp - 1'b1;
                end
            end
        endcase
    end

endmodule

// File: rtl/far_path_pipe.sv
// Two-stage handshaked far-path adder: swap/align, then add/normalise.
// Optional tag sideband enabled by defining FAR_PATH_PIPE_TAG_EN.
module far_path_pipe
    import far_path_pipe_pkg::*;
#(
    parameter int EXPWIDTH  = 8,
    parameter int PRECISION = 48,
    parameter int OUTPC     = 24,
    parameter int TAG_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic                 a_sign_i,
    input  logic                 b_sign_i,
    input  logic [EXPWIDTH-1:0]  a_exp_i,
    input  logic [EXPWIDTH-1:0]  b_exp_i,
    input  logic [PRECISION-1:0] a_sig_i,
    input  logic [PRECISION-1:0] b_sig_i,
    input  logic                 op_sub_i,
    input  logic                 small_add_i,
`ifdef FAR_PATH_PIPE_TAG_EN
    input  logic [TAG_WIDTH-1:0] tag_i,
    output logic [TAG_WIDTH-1:0] tag_o,
`endif
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic                 result_sign_o,
    output logic [EXPWIDTH-1:0]  result_exp_o,
    output logic [OUTPC+2:0]     result_sig_o,
    output logic                 near_o,
    output logic                 exp_ovf_o
);
    localparam int SW = PRECISION + 2;
    localparam int AW = add_width(PRECISION);

    if (PRECISION < OUTPC + 1 || TAG_WIDTH < 1) begin : g_param_check
        $error("far_path_pipe: bad parameters");
    end

    function automatic logic [SW:0] shift_right_jam(
        input logic [SW-1:0]       x,
        input logic [EXPWIDTH-1:0] d
    );
        logic [2*SW-1:0] wide;
        int              amt;
        amt  = (int'(d) >= SW) ? SW : int'(d);
        wide = {x, {SW{1'b0}}} >> amt;
        return {wide[2*SW-1:SW], |wide[SW-1:0]};
    endfunction

    logic s1_valid, s2_valid, s2_ready, in_fire, s1_fire;

    assign s2_ready    = !s2_valid || out_ready_i;
    assign in_ready_o  = !s1_valid || s2_ready;
    assign in_fire     = in_valid_i && in_ready_o;
    assign s1_fire     = s1_valid && s2_ready;
    assign out_valid_o = s2_valid;

    // Stage 1: swap and align
    logic                 swap, effsub, near, sign;
    logic [EXPWIDTH-1:0]  l_exp, s_exp, d;
    logic [PRECISION-1:0] l_sig, s_sig;
    logic [SW:0]          jam;

    always_comb begin
        effsub = a_sign_i ^ b_sign_i ^ op_sub_i;
        swap   = (b_exp_i > a_exp_i) ||
                 (b_exp_i == a_exp_i && b_sig_i > a_sig_i);
        l_exp  = swap ? b_exp_i : a_exp_i;
        s_exp  = swap ? a_exp_i : b_exp_i;
        l_sig  = swap ? b_sig_i : a_sig_i;
        s_sig  = swap ? a_sig_i : b_sig_i;
        d      = l_exp - s_exp;
        near   = effsub && (d < EXPWIDTH'(2));
        sign   = swap ? (b_sign_i ^ op_sub_i) : a_sign_i;
        jam    = shift_right_jam({s_sig, 2'b00}, d);
    end

    logic [EXPWIDTH-1:0]  s1_l_exp;
    logic [PRECISION-1:0] s1_l_sig;
    logic [SW-1:0]        s1_main;
    logic                 s1_sticky, s1_effsub, s1_sign, s1_near, s1_small;

    // Stage 2: add and normalise
    logic [AW-1:0]        a_ext, b_ext, sum;
    logic [OUTPC+2:0]     n_sig;
    logic [EXPWIDTH-1:0]  n_exp;
    logic                 n_ovf;

    assign a_ext = {1'b0, s1_l_sig, 3'b000};
    assign b_ext = {1'b0, s1_main, s1_sticky};
    assign sum   = a_ext + (s1_effsub ? (~b_ext + 1'b1) : b_ext);

    far_path_pipe_norm #(
        .EXPWIDTH (EXPWIDTH),
        .PRECISION(PRECISION),
        .OUTPC    (OUTPC)
    ) u_norm (
        .sum      (sum),
        .small_add(s1_small),
        .l_exp    (s1_l_exp),
        .sig      (n_sig),
        .res_exp  (n_exp),
        .exp_ovf  (n_ovf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (in_ready_o) s1_valid <= in_valid_i;
            if (s2_ready)   s2_valid <= s1_valid;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_l_exp  <= '0;
            s1_l_sig  <= '0;
            s1_main   <= '0;
            s1_sticky <= 1'b0;
            s1_effsub <= 1'b0;
            s1_sign   <= 1'b0;
            s1_near   <= 1'b0;
            s1_small  <= 1'b0;
        end else if (in_fire) begin
            s1_l_exp  <= l_exp;
            s1_l_sig  <= l_sig;
            s1_main   <= jam[SW:1];
            s1_sticky <= jam[0];
            s1_effsub <= effsub;
            s1_sign   <= sign;
            s1_near   <= near;
            s1_small  <= small_add_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_sign_o <= 1'b0;
            result_exp_o  <= '0;
            result_sig_o  <= '0;
            near_o        <= 1'b0;
            exp_ovf_o     <= 1'b0;
        end else if (s1_fire) begin
            result_sign_o <= s1_sign;
            result_exp_o  <= n_exp;
            result_sig_o  <= n_sig;
            near_o        <= s1_near;
            exp_ovf_o     <= n_ovf;
        end
    end

`ifdef FAR_PATH_PIPE_TAG_EN
    logic [TAG_WIDTH-1:0] s1_tag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_tag <= '0;
            tag_o  <= '0;
        end else begin
            if (in_fire) s1_tag <= tag_i;
            if (s1_fire) tag_o  <= s1_tag;
        end
    end
`endif

endmodule
